div_timer: RTL and testbench
============================

DIV_TIMER -- requirements
Module: div_timer

Interface
REQ-001 SHALL have parameter DIV_W, default 16: free-running divider width, at least 10.
REQ-002 SHALL have parameter NCH, default 1: number of timer channels, 1..4.
REQ-003 SHALL have parameter FS_BIT, default 12: divider bit that clocks the frame sequencer.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port nreset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port addr, input, 4: register select; 0=DIV; 1+3k=TIMA[k]; 2+3k=TMA[k]; 3+3k=TAC[k].
REQ-007 SHALL have port cpu_wr, input, 1: write strobe, one access per cycle.
REQ-008 SHALL have port d_in, input, 8: write data.
REQ-009 SHALL have port d_out, output, 8: combinational read data; unmapped addresses read 0xFF.
REQ-010 SHALL have port irq, output, NCH: one-cycle overflow pulse per channel.
REQ-011 SHALL have port fs_step, output, 3: frame-sequencer step.
REQ-012 SHALL have port fs_len, output, 1: length-clock pulse.
REQ-013 SHALL have port fs_sweep, output, 1: sweep-clock pulse.
REQ-014 SHALL have port fs_env, output, 1: envelope-clock pulse.

Function
REQ-015 DIV SHALL increment by 1 every cycle and wrap modulo 2^DIV_W.
REQ-016 Any write to address 0 SHALL clear DIV to 0 in that cycle; data is ignored.
REQ-017 Reading address 0 SHALL return DIV[DIV_W-1:DIV_W-8].
REQ-018 TAC[k] SHALL be 3 bits: bit2 enables the channel, bits1:0 select the tap. Taps: 00=bit9, 01=bit3, 10=bit5, 11=bit7. TAC reads return {5'b11111, TAC}.
REQ-019 Per channel, in[k] = TAC[k][2] & DIV[tap]. TIMA[k] SHALL increment on the cycle after in[k] goes 1 to 0.
REQ-020 The 1 to 0 transition in REQ-019 SHALL count whatever its cause (count, DIV clear, TAC write). It is not masked.
REQ-021 On a 0xFF to 0x00 wrap, TIMA SHALL read 0x00 for exactly one cycle (state OVF).
REQ-022 In the cycle after OVF (state RELOAD), TIMA SHALL load TMA and irq[k] SHALL be 1 for that cycle only.
REQ-023 Per-channel state machine: IDLE to OVF on wrap; OVF to RELOAD unconditionally; RELOAD to IDLE. RELOAD with a coincident wrap is impossible.
REQ-024 A TIMA write in IDLE SHALL override a same-cycle increment.
REQ-025 A TIMA write in OVF SHALL load the data, cancel the reload and the irq, and return to IDLE.
REQ-026 A TIMA write in RELOAD SHALL be ignored; TMA wins.
REQ-027 A TMA write in RELOAD SHALL also load the new value into TIMA.
REQ-028 Channels SHALL be fully independent and share only DIV.

Reset
REQ-029 nreset low SHALL asynchronously clear DIV, TIMA, TMA, TAC, channel states (to IDLE), the frame-sequencer step and all edge-detect registers. irq, fs_* and fs_step SHALL then be 0.
REQ-030 Reset release mid-operation SHALL resume counting from the cleared state, with no spurious edge.

Configuration
REQ-031 DIV_TIMER_FRAME_SEQ_EN defined: a 3-bit step counter SHALL advance on each 1 to 0 transition of DIV[FS_BIT], including one caused by a DIV write.
REQ-032 With the macro, on that advance: fs_len SHALL pulse for one cycle on new even steps; fs_sweep on steps 2 and 6; fs_env on step 7. fs_step shows the current step.
REQ-033 Macro undefined: all fs_* outputs SHALL be constant 0 and no frame-sequencer logic SHALL be instantiated.

Structure
REQ-034 A shared package SHALL hold the address constants, the tap-select table, the channel state enum (IDLE/OVF/RELOAD) and the frame-step decode constants.
REQ-035 One sub-module, div_timer_chan (TIMA/TMA/TAC, edge detect, state machine), SHALL be instantiated NCH times via generate.

Verification
REQ-036 Reset, then TAC0=0b101 and TMA0=0xFE: TIMA0 increments every 16 cycles; wraps to 0x00 and, one cycle later, reads 0xFE with irq[0]=1 for 1 cycle.
REQ-037 TAC0=0b100 with DIV bit9 high, then write DIV: TIMA0 +1 in the next cycle.
REQ-038 TAC0 enabled with bit9 high, then write TAC0=0b000: TIMA0 +1.
REQ-039 Write TIMA0=0x42 in the OVF cycle: TIMA0 reads 0x42, no irq, no reload.
REQ-040 Write TMA0=0x80 in the RELOAD cycle: TIMA0 reads 0x80.
REQ-041 With the macro and FS_BIT=12, run 8*8192 cycles from reset: fs_step runs 1..7 then 0. 4 fs_len, 2 fs_sweep and 1 fs_env pulses, each one cycle wide.

Source files
------------

// File: rtl/div_timer_pkg.sv
// Shared constants and types for the divider/timer block: register map, tap table,
// channel state encoding and frame-sequencer step decode.
package div_timer_pkg;

  localparam logic [3:0] AddrDiv = 4'd0;

  // Channel k owns addresses ChanBase + ChanStride*k + {OffTima, OffTma, OffTac}.
  localparam int unsigned ChanBase   = 1;
  localparam int unsigned ChanStride = 3;
  localparam int unsigned OffTima    = 0;
  localparam int unsigned OffTma     = 1;
  localparam int unsigned OffTac     = 2;

  localparam logic [3:0] TapBit00 = 4'd9;
  localparam logic [3:0] TapBit01 = 4'd3;
  localparam logic [3:0] TapBit10 = 4'd5;
  localparam logic [3:0] TapBit11 = 4'd7;

  typedef enum logic [1:0] {
    StIdle,
    StOvf,
    StReload
  } chan_state_e;

  localparam logic [2:0] FsSweepStepA = 3'd2;
  localparam logic [2:0] FsSweepStepB = 3'd6;
  localparam logic [2:0] FsEnvStep    = 3'd7;

  function automatic logic tap_sel(input logic [1:0] sel, input logic [9:0] div_lo);
    logic bit_val;
    unique case (sel)
      2'b00:   bit_val = div_lo[TapBit00];
      2'b01:   bit_val = div_lo[TapBit01];
      2'b10:   bit_val = div_lo[TapBit10];
      default: bit_val = div_lo[TapBit11];
    endcase
    return bit_val;
  endfunction

  function automatic logic [3:0] chan_addr(input int unsigned k, input int unsigned off);
    return 4'(ChanBase + ChanStride * k + off);
  endfunction

endpackage

// File: rtl/div_timer_chan.sv
// One timer channel: TIMA/TMA/TAC registers, falling-edge detect on the selected
// divider tap, and the IDLE/OVF/RELOAD overflow sequencer.
module div_timer_chan
  import div_timer_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic [9:0] div_lo_i,
  input  logic       wr_tima_i,
  input  logic       wr_tma_i,
  input  logic       wr_tac_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] tima_o,
  output logic [7:0] tma_o,
  output logic [2:0] tac_o,
  output logic       irq_o
);

  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  chan_state_e state_q, state_d;
  logic        in_q, in_now, fall;
  logic        irq_q;

  // Any 1->0 of the gated tap counts, including ones caused by DIV or TAC writes.
  assign in_now = tac_q[2] & tap_sel(tac_q[1:0], div_lo_i);
  assign fall   = in_q & ~in_now;

  always_comb begin
    tma_d   = wr_tma_i ? wdata_i : tma_q;
    tac_d   = wr_tac_i ? wdata_i[2:0] : tac_q;
    tima_d  = tima_q;
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wr_tima_i) begin
          tima_d = wdata_i;
        end else if (fall) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = StOvf;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      StOvf: begin
        if (wr_tima_i) begin
          tima_d  = wdata_i;
          state_d = StIdle;
        end else begin
          tima_d  = tma_d;
          state_d = StReload;
        end
      end
      StReload: begin
        // TIMA writes are dropped here; a TMA write lands in TIMA too.
        tima_d  = wr_tma_i ? wdata_i : tima_q + {7'd0, fall};
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
      state_q <= StIdle;
      in_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      state_q <= state_d;
      in_q    <= in_now;
      irq_q   <= (state_d == StReload);
    end
  end

  assign tima_o = tima_q;
  assign tma_o  = tma_q;
  assign tac_o  = tac_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/div_timer.sv
// Free-running divider with NCH timer channels; the optional frame sequencer is
// built only when DIV_TIMER_FRAME_SEQ_EN is defined.
module div_timer
  import div_timer_pkg::*;
#(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned NCH    = 1,
  parameter int unsigned FS_BIT = 12
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic [3:0]     addr,
  input  logic           cpu_wr,
  input  logic [7:0]     d_in,
  output logic [7:0]     d_out,
  output logic [NCH-1:0] irq,
  output logic [2:0]     fs_step,
  output logic           fs_len,
  output logic           fs_sweep,
  output logic           fs_env
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       rd_chain [NCH+1];

  always_comb begin
    div_d = div_q + 1'b1;
    if (cpu_wr && (addr == AddrDiv)) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign rd_chain[0] = (addr == AddrDiv) ? div_q[DIV_W-1 -: 8] : 8'hFF;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    logic       hit_tima, hit_tma, hit_tac;
    logic [7:0] tima_w, tma_w;
    logic [2:0] tac_w;

    assign hit_tima = (addr == chan_addr(k, OffTima));
    assign hit_tma  = (addr == chan_addr(k, OffTma));
    assign hit_tac  = (addr == chan_addr(k, OffTac));

    div_timer_chan u_chan (
      .clk       (clk),
      .nreset    (nreset),
      .div_lo_i  (div_q[9:0]),
      .wr_tima_i (cpu_wr && hit_tima),
      .wr_tma_i  (cpu_wr && hit_tma),
      .wr_tac_i  (cpu_wr && hit_tac),
      .wdata_i   (d_in),
      .tima_o    (tima_w),
      .tma_o     (tma_w),
      .tac_o     (tac_w),
      .irq_o     (irq[k])
    );

    assign rd_chain[k+1] = hit_tima ? tima_w :
                           hit_tma  ? tma_w  :
                           hit_tac  ? {5'b11111, tac_w} : rd_chain[k];
  end

  assign d_out = rd_chain[NCH];

`ifdef DIV_TIMER_FRAME_SEQ_EN
  logic       fs_in_q, fs_fall;
  logic [2:0] step_q, step_d;
  logic       len_q, sweep_q, env_q;

  assign fs_fall = fs_in_q & ~div_q[FS_BIT];
  assign step_d  = fs_fall ? step_q + 3'd1 : step_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fs_in_q <= 1'b0;
      step_q  <= 3'd0;
      len_q   <= 1'b0;
      sweep_q <= 1'b0;
      env_q   <= 1'b0;
    end else begin
      fs_in_q <= div_q[FS_BIT];
      step_q  <= step_d;
      len_q   <= fs_fall & ~step_d[0];
      sweep_q <= fs_fall & ((step_d == FsSweepStepA) || (step_d == FsSweepStepB));
      env_q   <= fs_fall & (step_d == FsEnvStep);
    end
  end

  assign fs_step  = step_q;
  assign fs_len   = len_q;
  assign fs_sweep = sweep_q;
  assign fs_env   = env_q;
`else
  assign fs_step  = 3'd0;
  assign fs_len   = 1'b0;
  assign fs_sweep = 1'b0;
  assign fs_env   = 1'b0;
`endif

endmodule

// File: tb/tb_div_timer.sv
// Directed bench for div_timer (two channels); frame-sequencer checks depend on
// whether DIV_TIMER_FRAME_SEQ_EN is defined.
module tb_div_timer;

  logic       clk;
  logic       nreset;
  logic [3:0] addr;
  logic       cpu_wr;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic [1:0] irq;
  logic [2:0] fs_step;
  logic       fs_len, fs_sweep, fs_env;

  int errors = 0;
  int checks = 0;
  int div_m  = 0;  // expected DIV value, advanced by the bench itself
  logic [7:0] v;

  div_timer #(.DIV_W(16), .NCH(2), .FS_BIT(12)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .addr     (addr),
    .cpu_wr   (cpu_wr),
    .d_in     (d_in),
    .d_out    (d_out),
    .irq      (irq),
    .fs_step  (fs_step),
    .fs_len   (fs_len),
    .fs_sweep (fs_sweep),
    .fs_env   (fs_env)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    div_m += n;
  endtask

  task automatic tick_to(input int t);
    tick(t - div_m);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr   = a;
    d_in   = d;
    cpu_wr = 1'b1;
    @(posedge clk);
    #1;
    cpu_wr = 1'b0;
    addr   = 4'd0;
    if (a == 4'd0) div_m = 0;
    else div_m += 1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] val);
    addr = a;
    #1;
    val = d_out;
  endtask

  task automatic do_reset();
    #1;
    nreset = 1'b0;
    cpu_wr = 1'b0;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    div_m  = 0;
  endtask

  task automatic test_reset();
    rd(4'd0, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_div got=%h exp=00", v); end
    rd(4'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_tima0 got=%h exp=00", v); end
    rd(4'd2, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_tma0 got=%h exp=00", v); end
    rd(4'd3, v); checks++;
    if (v !== 8'hF8) begin errors++; $display("FAIL reset_tac0 got=%h exp=f8", v); end
    checks++;
    if ({irq, fs_step, fs_len, fs_sweep, fs_env} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=0", {irq, fs_step, fs_len, fs_sweep, fs_env});
    end
    @(posedge clk);
    #1;
    nreset = 1'b1;
    div_m  = 0;
    rd(4'd7, v); checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL unmapped7 got=%h exp=ff", v); end
    rd(4'd15, v); checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL unmapped15 got=%h exp=ff", v); end
    tick_to(256);
    rd(4'd0, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL div_read_256 got=%h exp=01", v); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    wr(4'd3, 8'h05);
    wr(4'd2, 8'hFE);
    tick_to(16); rd(4'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL cnt_16 got=%h exp=00", v); end
    tick_to(17); rd(4'd1, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL cnt_17 got=%h exp=01", v); end
    tick_to(32); rd(4'd1, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL cnt_32 got=%h exp=01", v); end
    tick_to(33); rd(4'd1, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL cnt_33 got=%h exp=02", v); end
    wr(4'd1, 8'hFE);
    tick_to(49); rd(4'd1, v); checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL cnt_49 got=%h exp=ff", v); end
    tick_to(65); rd(4'd1, v); checks++;
    if (v !== 8'h00 || irq !== 2'b00) begin
      errors++; $display("FAIL ovf_cycle got=%h irq=%b exp=00 irq=00", v, irq);
    end
    tick_to(66); rd(4'd1, v); checks++;
    if (v !== 8'hFE || irq !== 2'b01) begin
      errors++; $display("FAIL reload_cycle got=%h irq=%b exp=fe irq=01", v, irq);
    end
    tick_to(67); rd(4'd1, v); checks++;
    if (v !== 8'hFE || irq !== 2'b00) begin
      errors++; $display("FAIL after_reload got=%h irq=%b exp=fe irq=00", v, irq);
    end
  endtask

  task automatic test_idle_override();
    do_reset();
    wr(4'd3, 8'h05);
    tick_to(16);
    wr(4'd1, 8'h20);
    rd(4'd1, v); checks++;
    if (v !== 8'h20) begin errors++; $display("FAIL idle_wr_override got=%h exp=20", v); end
    tick_to(33); rd(4'd1, v); checks++;
    if (v !== 8'h21) begin errors++; $display("FAIL idle_wr_then_inc got=%h exp=21", v); end
  endtask

  task automatic test_div_write();
    do_reset();
    wr(4'd3, 8'h04);
    tick_to(520);
    rd(4'd0, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL div_read_520 got=%h exp=02", v); end
    wr(4'd0, 8'h5A);
    rd(4'd0, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL div_cleared got=%h exp=00", v); end
    rd(4'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL divwr_before got=%h exp=00", v); end
    tick(1); rd(4'd1, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL divwr_edge_inc got=%h exp=01", v); end
  endtask

  task automatic test_tac_write();
    do_reset();
    wr(4'd3, 8'h04);
    tick_to(520);
    wr(4'd3, 8'h00);
    rd(4'd3, v); checks++;
    if (v !== 8'hF8) begin errors++; $display("FAIL tac_off_read got=%h exp=f8", v); end
    tick(1); rd(4'd1, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL tacwr_edge_inc got=%h exp=01", v); end
    tick_to(1100); rd(4'd1, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL tac_disabled_hold got=%h exp=01", v); end
  endtask

  task automatic setup_ovf();
    do_reset();
    wr(4'd3, 8'h05);
    wr(4'd2, 8'h10);
    wr(4'd1, 8'hFF);
  endtask

  task automatic test_ovf_write();
    setup_ovf();
    tick_to(17); rd(4'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL ovf_state got=%h exp=00", v); end
    wr(4'd1, 8'h42);
    rd(4'd1, v); checks++;
    if (v !== 8'h42 || irq !== 2'b00) begin
      errors++; $display("FAIL ovf_wr got=%h irq=%b exp=42 irq=00", v, irq);
    end
    tick(1); rd(4'd1, v); checks++;
    if (v !== 8'h42 || irq !== 2'b00) begin
      errors++; $display("FAIL ovf_wr_next got=%h irq=%b exp=42 irq=00", v, irq);
    end
  endtask

  task automatic test_reload_writes();
    setup_ovf();
    tick_to(18); rd(4'd1, v); checks++;
    if (v !== 8'h10 || irq !== 2'b01) begin
      errors++; $display("FAIL reload_state got=%h irq=%b exp=10 irq=01", v, irq);
    end
    wr(4'd2, 8'h80);
    rd(4'd1, v); checks++;
    if (v !== 8'h80 || irq !== 2'b00) begin
      errors++; $display("FAIL reload_tma_wr got=%h irq=%b exp=80 irq=00", v, irq);
    end
    rd(4'd2, v); checks++;
    if (v !== 8'h80) begin errors++; $display("FAIL reload_tma_read got=%h exp=80", v); end
    setup_ovf();
    tick_to(18);
    wr(4'd1, 8'h33);
    rd(4'd1, v); checks++;
    if (v !== 8'h10) begin errors++; $display("FAIL reload_tima_ignored got=%h exp=10", v); end
  endtask

  task automatic test_channels();
    do_reset();
    wr(4'd6, 8'h06);
    rd(4'd6, v); checks++;
    if (v !== 8'hFE) begin errors++; $display("FAIL tac1_read got=%h exp=fe", v); end
    tick_to(64); rd(4'd4, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL ch1_64 got=%h exp=00", v); end
    tick_to(65); rd(4'd4, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL ch1_65 got=%h exp=01", v); end
    rd(4'd1, v); checks++;
    if (v !== 8'h00 || irq !== 2'b00) begin
      errors++; $display("FAIL ch0_idle got=%h irq=%b exp=00 irq=00", v, irq);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    wr(4'd3, 8'h05);
    wr(4'd1, 8'h7F);
    tick_to(12);
    nreset = 1'b0;
    #2;
    rd(4'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL async_clear_tima got=%h exp=00", v); end
    rd(4'd3, v); checks++;
    if (v !== 8'hF8) begin errors++; $display("FAIL async_clear_tac got=%h exp=f8", v); end
    @(posedge clk);
    #1;
    nreset = 1'b1;
    div_m  = 0;
    tick(5); rd(4'd1, v); checks++;
    if (v !== 8'h00 || irq !== 2'b00) begin
      errors++; $display("FAIL no_spurious got=%h irq=%b exp=00 irq=00", v, irq);
    end
    wr(4'd3, 8'h05);
    tick_to(17); rd(4'd1, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL resume_count got=%h exp=01", v); end
  endtask

  task automatic test_frame_seq();
`ifdef DIV_TIMER_FRAME_SEQ_EN
    int len_n = 0, sweep_n = 0, env_n = 0, wide_n = 0, steps = 0, bad = 0;
    logic [2:0] exp_step = 3'd0;
    logic [2:0] prev_step = 3'd0;
    logic       p_len = 1'b0, p_sweep = 1'b0, p_env = 1'b0;
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      tick(1);
      if (fs_step !== prev_step) begin
        steps++;
        exp_step = exp_step + 3'd1;
        checks++;
        if (fs_step !== exp_step) begin
          errors++; $display("FAIL fs_step_seq got=%0d exp=%0d", fs_step, exp_step);
        end
      end
      if (fs_len) len_n++;
      if (fs_sweep) sweep_n++;
      if (fs_env) begin
        env_n++;
        if (fs_step !== 3'd7) bad++;
      end
      if ((fs_len && p_len) || (fs_sweep && p_sweep) || (fs_env && p_env)) wide_n++;
      prev_step = fs_step;
      p_len = fs_len; p_sweep = fs_sweep; p_env = fs_env;
    end
    checks++;
    if (steps != 8 || fs_step !== 3'd0) begin
      errors++; $display("FAIL fs_steps got=%0d final=%0d exp=8 final=0", steps, fs_step);
    end
    checks++;
    if (len_n != 4) begin errors++; $display("FAIL fs_len_count got=%0d exp=4", len_n); end
    checks++;
    if (sweep_n != 2) begin errors++; $display("FAIL fs_sweep_count got=%0d exp=2", sweep_n); end
    checks++;
    if (env_n != 1 || bad != 0) begin
      errors++; $display("FAIL fs_env_count got=%0d misplaced=%0d exp=1 misplaced=0", env_n, bad);
    end
    checks++;
    if (wide_n != 0) begin errors++; $display("FAIL fs_pulse_width got=%0d exp=0", wide_n); end
`else
    int nz = 0;
    do_reset();
    for (int i = 0; i < 9000; i++) begin
      tick(1);
      if ({fs_step, fs_len, fs_sweep, fs_env} !== 6'd0) nz++;
    end
    checks++;
    if (nz != 0) begin errors++; $display("FAIL fs_disabled_zero got=%0d exp=0", nz); end
`endif
  endtask

  initial begin
    nreset = 1'b0;
    cpu_wr = 1'b0;
    addr   = 4'd0;
    d_in   = 8'h00;
    #23;
    test_reset();
    test_count_wrap();
    test_idle_override();
    test_div_write();
    test_tac_write();
    test_ovf_write();
    test_reload_writes();
    test_channels();
    test_reset_midrun();
    test_frame_seq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
